// File: rtl/rot_ctrl.sv
// rot_ctrl: rotation core sequencer between the register block and the DMA port.
//
// On a START rising edge the image configuration is latched and the source image
// is walked pixel by pixel in row-major order. Every pixel costs one DMA read from
// the source image followed by one DMA write to its rotated destination address.
//
// Ports:
//   I_ROTCTRL_CLK / I_ROTCTRL_RESET  clock, asynchronous active-high reset
//   I_ROTCTRL_START                  start request (rising edge only)
//   I_ROTCTRL_SRST                   synchronous soft reset
//   I_ROTCTRL_SRC_IMG/DST_IMG        source / destination byte base addresses
//   I_ROTCTRL_IMG_H/IMG_W            source height / width
//   I_ROTCTRL_MODE/DIR               rotation amount and direction
//   I_ROTCTRL_INTR_MASK/INTR_CLEAR   interrupt mask, status flag clear
//   I_ROTCTRL_DMA_ACK/DMA_RDATA      DMA accept strobe and read pixel
//   O_ROTCTRL_DMA_*                  DMA request, direction, address, write pixel
//   O_ROTCTRL_NEW_H/NEW_W            rotated dimensions
//   O_ROTCTRL_BUSY                   operation in progress
//   O_ROTCTRL_BEF_MASK/AFT_MASK      started / completed status flags
//   O_ROTCTRL_INTR                   registered interrupt
module rot_ctrl #(
  parameter int ADDR_W = 32,
  parameter int PIX_W  = 8,
  parameter int DIM_W  = 16
) (
  input  logic              I_ROTCTRL_CLK,
  input  logic              I_ROTCTRL_RESET,
  input  logic              I_ROTCTRL_START,
  input  logic              I_ROTCTRL_SRST,
  input  logic [ADDR_W-1:0] I_ROTCTRL_SRC_IMG,
  input  logic [ADDR_W-1:0] I_ROTCTRL_DST_IMG,
  input  logic [DIM_W-1:0]  I_ROTCTRL_IMG_H,
  input  logic [DIM_W-1:0]  I_ROTCTRL_IMG_W,
  input  logic [1:0]        I_ROTCTRL_MODE,
  input  logic              I_ROTCTRL_DIR,
  input  logic              I_ROTCTRL_INTR_MASK,
  input  logic              I_ROTCTRL_INTR_CLEAR,
  input  logic              I_ROTCTRL_DMA_ACK,
  input  logic [PIX_W-1:0]  I_ROTCTRL_DMA_RDATA,
  output logic              O_ROTCTRL_DMA_REQ,
  output logic              O_ROTCTRL_DMA_WR,
  output logic [ADDR_W-1:0] O_ROTCTRL_DMA_ADDR,
  output logic [PIX_W-1:0]  O_ROTCTRL_DMA_WDATA,
  output logic [DIM_W-1:0]  O_ROTCTRL_NEW_H,
  output logic [DIM_W-1:0]  O_ROTCTRL_NEW_W,
  output logic              O_ROTCTRL_BUSY,
  output logic              O_ROTCTRL_BEF_MASK,
  output logic              O_ROTCTRL_AFT_MASK,
  output logic              O_ROTCTRL_INTR
);

  localparam int BPP = PIX_W / 8;
  localparam logic [ADDR_W-1:0] BPP_A = ADDR_W'(BPP);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              start_prev_q, start_prev_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DIM_W-1:0]  h_q, h_d;
  logic [DIM_W-1:0]  w_q, w_d;
  logic [DIM_W-1:0]  r_q, r_d;
  logic [DIM_W-1:0]  c_q, c_d;
  logic [DIM_W-1:0]  new_h_q, new_h_d;
  logic [DIM_W-1:0]  new_w_q, new_w_d;
  logic [1:0]        rot_q, rot_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              bef_q, bef_d;
  logic              aft_q, aft_d;
  logic              intr_q, intr_d;

  logic              start_rise;
  logic [1:0]        rot_in;
  logic              last_pix;
  logic [ADDR_W-1:0] rr, cc, hh, ww;
  logic [ADDR_W-1:0] src_off, dst_off, src_addr, dst_addr;

  // Zero-extend (or truncate) a dimension into address width so that all
  // offset arithmetic wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [DIM_W-1:0] v);
    return ADDR_W'(v);
  endfunction

  // Counter-clockwise turns are folded into clockwise quarter turns: -MODE mod 4.
  assign rot_in     = I_ROTCTRL_DIR ? (2'd0 - I_ROTCTRL_MODE) : I_ROTCTRL_MODE;
  assign start_rise = I_ROTCTRL_START & ~start_prev_q;
  assign last_pix   = (r_q == h_q - ONE_D) && (c_q == w_q - ONE_D);

  // Address generation from the current (r,c) and the latched geometry.
  always_comb begin
    rr      = to_addr(r_q);
    cc      = to_addr(c_q);
    hh      = to_addr(h_q);
    ww      = to_addr(w_q);
    src_off = rr * ww + cc;
    dst_off = '0;
    case (rot_q)
      2'd0:    dst_off = rr * ww + cc;
      2'd1:    dst_off = cc * hh + (hh - rr - ONE_A);
      2'd2:    dst_off = (hh - rr - ONE_A) * ww + (ww - cc - ONE_A);
      default: dst_off = (ww - cc - ONE_A) * hh + rr;
    endcase
    src_addr = src_q + src_off * BPP_A;
    dst_addr = dst_q + dst_off * BPP_A;
  end

  // Next-state and register update logic.
  always_comb begin
    state_d      = state_q;
    start_prev_d = I_ROTCTRL_START;
    src_d        = src_q;
    dst_d        = dst_q;
    h_d          = h_q;
    w_d          = w_q;
    r_d          = r_q;
    c_d          = c_q;
    new_h_d      = new_h_q;
    new_w_d      = new_w_q;
    rot_d        = rot_q;
    pix_d        = pix_q;
    bef_d        = bef_q;
    aft_d        = aft_q;
    intr_d       = ~I_ROTCTRL_INTR_MASK & (bef_q | aft_q);

    // Clear first so that a set event later in this block takes priority.
    if (I_ROTCTRL_INTR_CLEAR) begin
      bef_d = 1'b0;
      aft_d = 1'b0;
    end

    if (I_ROTCTRL_SRST) begin
      // Soft reset aborts the walk; any ACK in this cycle is dropped.
      state_d = S_IDLE;
      bef_d   = 1'b0;
      aft_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            src_d   = I_ROTCTRL_SRC_IMG;
            dst_d   = I_ROTCTRL_DST_IMG;
            h_d     = I_ROTCTRL_IMG_H;
            w_d     = I_ROTCTRL_IMG_W;
            rot_d   = rot_in;
            r_d     = '0;
            c_d     = '0;
            new_h_d = rot_in[0] ? I_ROTCTRL_IMG_W : I_ROTCTRL_IMG_H;
            new_w_d = rot_in[0] ? I_ROTCTRL_IMG_H : I_ROTCTRL_IMG_W;
            bef_d   = 1'b1;
            aft_d   = 1'b0;
            if ((I_ROTCTRL_IMG_H == '0) || (I_ROTCTRL_IMG_W == '0)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RD;
            end
          end
        end
        S_RD: begin
          if (I_ROTCTRL_DMA_ACK) begin
            pix_d   = I_ROTCTRL_DMA_RDATA;
            state_d = S_WR;
          end
        end
        S_WR: begin
          if (I_ROTCTRL_DMA_ACK) begin
            if (last_pix) begin
              state_d = S_DONE;
            end else begin
              if (c_q == w_q - ONE_D) begin
                c_d = '0;
                r_d = r_q + ONE_D;
              end else begin
                c_d = c_q + ONE_D;
              end
              state_d = S_RD;
            end
          end
        end
        default: begin
          aft_d   = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge I_ROTCTRL_CLK or posedge I_ROTCTRL_RESET) begin
    if (I_ROTCTRL_RESET) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      h_q          <= '0;
      w_q          <= '0;
      r_q          <= '0;
      c_q          <= '0;
      new_h_q      <= '0;
      new_w_q      <= '0;
      rot_q        <= '0;
      pix_q        <= '0;
      bef_q        <= 1'b0;
      aft_q        <= 1'b0;
      intr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      h_q          <= h_d;
      w_q          <= w_d;
      r_q          <= r_d;
      c_q          <= c_d;
      new_h_q      <= new_h_d;
      new_w_q      <= new_w_d;
      rot_q        <= rot_d;
      pix_q        <= pix_d;
      bef_q        <= bef_d;
      aft_q        <= aft_d;
      intr_q       <= intr_d;
    end
  end

  // DMA request fields depend on the state only, so they stay stable until ACK.
  assign O_ROTCTRL_DMA_REQ   = (state_q == S_RD) || (state_q == S_WR);
  assign O_ROTCTRL_DMA_WR    = (state_q == S_WR);
  assign O_ROTCTRL_DMA_ADDR  = (state_q == S_RD) ? src_addr :
                               (state_q == S_WR) ? dst_addr : '0;
  assign O_ROTCTRL_DMA_WDATA = (state_q == S_WR) ? pix_q : '0;
  assign O_ROTCTRL_NEW_H     = new_h_q;
  assign O_ROTCTRL_NEW_W     = new_w_q;
  assign O_ROTCTRL_BUSY      = (state_q != S_IDLE);
  assign O_ROTCTRL_BEF_MASK  = bef_q;
  assign O_ROTCTRL_AFT_MASK  = aft_q;
  assign O_ROTCTRL_INTR      = intr_q;

endmodule

// File: tb/tb_rot_ctrl.sv
// tb_rot_ctrl: directed, table-driven bench for rot_ctrl with a small DMA
// responder model (source pixel value = row-major index) and hand sequences
// for zero-size images, soft reset and mid-operation START / INTR_CLEAR.
module tb_rot_ctrl;

  localparam logic [31:0] SRC_BASE = 32'h1000;
  localparam logic [31:0] DST_BASE = 32'h2000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        srst;
  logic [31:0] src_img;
  logic [31:0] dst_img;
  logic [15:0] img_h;
  logic [15:0] img_w;
  logic [1:0]  mode;
  logic        dir;
  logic        intr_mask;
  logic        intr_clear;
  logic        ack;
  logic [7:0]  rdata;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic [15:0] new_h;
  logic [15:0] new_w;
  logic        busy;
  logic        bef;
  logic        aft;
  logic        intr;

  rot_ctrl dut (
    .I_ROTCTRL_CLK        (clk),
    .I_ROTCTRL_RESET      (rst),
    .I_ROTCTRL_START      (start),
    .I_ROTCTRL_SRST       (srst),
    .I_ROTCTRL_SRC_IMG    (src_img),
    .I_ROTCTRL_DST_IMG    (dst_img),
    .I_ROTCTRL_IMG_H      (img_h),
    .I_ROTCTRL_IMG_W      (img_w),
    .I_ROTCTRL_MODE       (mode),
    .I_ROTCTRL_DIR        (dir),
    .I_ROTCTRL_INTR_MASK  (intr_mask),
    .I_ROTCTRL_INTR_CLEAR (intr_clear),
    .I_ROTCTRL_DMA_ACK    (ack),
    .I_ROTCTRL_DMA_RDATA  (rdata),
    .O_ROTCTRL_DMA_REQ    (req),
    .O_ROTCTRL_DMA_WR     (wr),
    .O_ROTCTRL_DMA_ADDR   (addr),
    .O_ROTCTRL_DMA_WDATA  (wdata),
    .O_ROTCTRL_NEW_H      (new_h),
    .O_ROTCTRL_NEW_W      (new_w),
    .O_ROTCTRL_BUSY       (busy),
    .O_ROTCTRL_BEF_MASK   (bef),
    .O_ROTCTRL_AFT_MASK   (aft),
    .O_ROTCTRL_INTR       (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         h;
    int         w;
    logic [1:0] mode;
    logic       dir;
    int         maxdly;
    int         nh;
    int         nw;
    int         dst[6];
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  int n_checks = 0;
  int n_err    = 0;

  // DMA responder state
  logic [7:0]  dst_mem[16];
  logic [31:0] cur_src;
  logic [31:0] cur_dst;
  int          cur_n;
  int          rd_idx;
  int          wr_count;
  bit          pending;
  int          dly;
  logic [31:0] hold_addr;
  logic        hold_wr;
  int          seq_bad;
  int          stab_bad;
  int          k;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // One clock: advance to the next falling edge, then act as the DMA slave.
  task automatic step(input int maxdly);
    logic [31:0] off;
    @(posedge clk);
    @(negedge clk);
    k++;
    ack = 1'b0;
    if (req === 1'b1) begin
      if (!pending) begin
        pending   = 1'b1;
        hold_addr = addr;
        hold_wr   = wr;
        dly       = $urandom_range(maxdly, 0);
      end else if ((addr !== hold_addr) || (wr !== hold_wr)) begin
        stab_bad++;
      end
      if (dly == 0) begin
        ack     = 1'b1;
        pending = 1'b0;
        if (wr === 1'b0) begin
          if (addr !== cur_src + 32'(rd_idx)) seq_bad++;
          rdata = rd_idx[7:0];
          rd_idx++;
        end else begin
          off = addr - cur_dst;
          if (off < 32'(cur_n)) dst_mem[off[3:0]] = wdata;
          else seq_bad++;
          wr_count++;
        end
      end else begin
        dly--;
      end
    end
  endtask

  // Called at a falling edge: drive a configuration and raise START.
  task automatic begin_op(input int h, input int w, input logic [1:0] m, input logic d);
    src_img  = SRC_BASE;
    dst_img  = DST_BASE;
    img_h    = 16'(h);
    img_w    = 16'(w);
    mode     = m;
    dir      = d;
    cur_src  = SRC_BASE;
    cur_dst  = DST_BASE;
    cur_n    = h * w;
    rd_idx   = 0;
    wr_count = 0;
    pending  = 1'b0;
    dly      = 0;
    seq_bad  = 0;
    stab_bad = 0;
    k        = 0;
    for (int i = 0; i < 16; i++) dst_mem[i] = 8'hEE;
    start = 1'b1;
  endtask

  // Full operation; cyc = clock edges from START rising to AFT_MASK seen high.
  task automatic run_op(input int h, input int w, input logic [1:0] m, input logic d,
                        input int maxdly, output int cyc);
    begin_op(h, w, m, d);
    cyc = -1;
    while ((cyc < 0) && (k < 400)) begin
      step(maxdly);
      if (k == 2) start = 1'b0;
      if (aft === 1'b1) cyc = k;
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int any_req;
    int bad_intr;
    int done_k;
    int any_busy;
    int h0_intr;

    vecs[0] = '{2, 3, 2'b01, 1'b0, 0, 3, 2, '{3, 0, 4, 1, 5, 2}};
    vecs[1] = '{2, 3, 2'b10, 1'b0, 0, 2, 3, '{5, 4, 3, 2, 1, 0}};
    vecs[2] = '{2, 3, 2'b01, 1'b1, 0, 3, 2, '{2, 5, 1, 4, 0, 3}};
    vecs[3] = '{2, 3, 2'b00, 1'b0, 0, 2, 3, '{0, 1, 2, 3, 4, 5}};
    vecs[4] = '{2, 3, 2'b11, 1'b0, 5, 3, 2, '{2, 5, 1, 4, 0, 3}};
    vecs[5] = '{2, 3, 2'b11, 1'b1, 0, 3, 2, '{3, 0, 4, 1, 5, 2}};
    vecs[6] = '{3, 2, 2'b01, 1'b0, 0, 2, 3, '{4, 2, 0, 5, 3, 1}};
    vecs[7] = '{2, 3, 2'b10, 1'b1, 3, 2, 3, '{5, 4, 3, 2, 1, 0}};

    rst = 1'b1; start = 1'b0; srst = 1'b0; src_img = '0; dst_img = '0;
    img_h = '0; img_w = '0; mode = '0; dir = 1'b0; intr_mask = 1'b0;
    intr_clear = 1'b0; ack = 1'b0; rdata = '0; k = 0; pending = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   int'(req),   0);
    chk("rst_wr",    int'(wr),    0);
    chk("rst_addr",  int'(addr),  0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_new_h", int'(new_h), 0);
    chk("rst_new_w", int'(new_w), 0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_bef",   int'(bef),   0);
    chk("rst_aft",   int'(aft),   0);
    chk("rst_intr",  int'(intr),  0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven rotations
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].h, vecs[i].w, vecs[i].mode, vecs[i].dir, vecs[i].maxdly, cyc);
      chk($sformatf("v%0d_new_h", i), int'(new_h), vecs[i].nh);
      chk($sformatf("v%0d_new_w", i), int'(new_w), vecs[i].nw);
      for (int j = 0; j < 6; j++)
        chk($sformatf("v%0d_dst%0d", i, j), int'(dst_mem[j]), vecs[i].dst[j]);
      if (vecs[i].maxdly == 0)
        chk($sformatf("v%0d_cycles", i), cyc, 2 * vecs[i].h * vecs[i].w + 2);
      else
        chk($sformatf("v%0d_done", i), int'(cyc > 0), 1);
      chk($sformatf("v%0d_addr_seq", i), seq_bad, 0);
      chk($sformatf("v%0d_req_stable", i), stab_bad, 0);
      step(0);
      chk($sformatf("v%0d_busy", i), int'(busy), 0);
      chk($sformatf("v%0d_bef", i),  int'(bef),  1);
      chk($sformatf("v%0d_aft", i),  int'(aft),  1);
      chk($sformatf("v%0d_intr", i), int'(intr), 1);
    end

    // Zero-height image, interrupt unmasked
    begin_op(0, 5, 2'b00, 1'b0);
    any_req = 0;
    h0_intr = 0;
    for (int i = 0; i < 5; i++) begin
      step(0);
      if (k == 2) start = 1'b0;
      if (req !== 1'b0) any_req++;
      if (k == 1) chk("h0_bef_k1", int'(bef), 1);
      if (k == 2) begin
        chk("h0_aft_k2",  int'(aft),  1);
        chk("h0_busy_k2", int'(busy), 0);
      end
      if (k == 3) h0_intr = int'(intr);
    end
    chk("h0_intr", h0_intr, 1);
    chk("h0_no_req", any_req, 0);
    chk("h0_new_h", int'(new_h), 0);
    chk("h0_new_w", int'(new_w), 5);

    // INTR_CLEAR, then zero-width image with interrupt masked
    intr_clear = 1'b1;
    step(0);
    intr_clear = 1'b0;
    step(0);
    chk("clr_bef",  int'(bef),  0);
    chk("clr_intr", int'(intr), 0);
    intr_mask = 1'b1;
    begin_op(3, 0, 2'b01, 1'b0);
    bad_intr = 0;
    for (int i = 0; i < 5; i++) begin
      step(0);
      if (k == 2) start = 1'b0;
      if (intr !== 1'b0) bad_intr++;
    end
    chk("mask_intr", bad_intr, 0);
    chk("mask_bef",  int'(bef), 1);
    chk("mask_aft",  int'(aft), 1);
    intr_mask = 1'b0;

    // Soft reset during the third write cycle, ACK in the same cycle
    begin_op(2, 3, 2'b01, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(0);
      if (k == 2) start = 1'b0;
      if (wr_count == 3) break;
    end
    chk("srst_reached", wr_count, 3);
    srst = 1'b1;
    step(0);
    srst = 1'b0;
    start = 1'b0;
    chk("srst_req",   int'(req),   0);
    chk("srst_busy",  int'(busy),  0);
    chk("srst_bef",   int'(bef),   0);
    chk("srst_aft",   int'(aft),   0);
    chk("srst_new_h", int'(new_h), 3);
    chk("srst_new_w", int'(new_w), 2);
    step(0);
    run_op(2, 3, 2'b01, 1'b0, 0, cyc);
    chk("post_srst_cycles", cyc, 14);
    for (int j = 0; j < 6; j++)
      chk($sformatf("post_srst_dst%0d", j), int'(dst_mem[j]), vecs[0].dst[j]);
    step(0);

    // Second START and config change mid-run, INTR_CLEAR in the DONE cycle
    begin_op(2, 3, 2'b10, 1'b0);
    done_k = -1;
    for (int i = 0; i < 60; i++) begin
      step(0);
      if (k == 2) start = 1'b0;
      if (k == 4) begin
        start = 1'b1; img_h = 16'd5; img_w = 16'd7; mode = 2'b01; dir = 1'b1;
        src_img = 32'h5000; dst_img = 32'h6000;
      end
      if (k == 5) start = 1'b0;
      if ((busy === 1'b1) && (req === 1'b0)) begin
        done_k = k;
        intr_clear = 1'b1;
        break;
      end
    end
    step(0);
    intr_clear = 1'b0;
    chk("mid_done_k", done_k, 13);
    chk("mid_aft",  int'(aft),  1);
    chk("mid_bef",  int'(bef),  0);
    chk("mid_busy", int'(busy), 0);
    any_busy = 0;
    for (int i = 0; i < 4; i++) begin
      step(0);
      if (busy !== 1'b0) any_busy++;
    end
    chk("mid_no_restart", any_busy, 0);
    chk("mid_reads",  rd_idx,   6);
    chk("mid_writes", wr_count, 6);
    chk("mid_addr_seq", seq_bad, 0);
    chk("mid_new_h", int'(new_h), 2);
    chk("mid_new_w", int'(new_w), 3);
    for (int j = 0; j < 6; j++)
      chk($sformatf("mid_dst%0d", j), int'(dst_mem[j]), vecs[1].dst[j]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rot_ctrl.md
Name: rot_ctrl

Overview:
Rotation core sequencer between the APB register block and the DMA port.
- On START, latches the image configuration and walks the source image pixel by pixel in row-major order.
- For each pixel it issues one DMA read, then one DMA write to the rotated destination address.
- Reports the rotated dimensions and before/after status flags back to the register block, and raises a maskable interrupt.

Parameters:
ADDR_W, 32, DMA byte-address width
PIX_W, 8, pixel width in bits (multiple of 8); BPP = PIX_W/8 bytes per pixel
DIM_W, 16, image height/width width

Ports:
I_ROTCTRL_CLK  in  1  core clock
I_ROTCTRL_RESET  in  1  asynchronous active-high reset
I_ROTCTRL_START  in  1  start request; acted on at rising edge only
I_ROTCTRL_SRST  in  1  soft reset (CTRL_RESET bit), synchronous, active-high
I_ROTCTRL_SRC_IMG  in  ADDR_W  source image base
I_ROTCTRL_DST_IMG  in  ADDR_W  destination image base
I_ROTCTRL_IMG_H  in  DIM_W  source height H
I_ROTCTRL_IMG_W  in  DIM_W  source width W
I_ROTCTRL_MODE  in  2  00=0deg, 01=90, 10=180, 11=270
I_ROTCTRL_DIR  in  1  0=clockwise, 1=counter-clockwise
I_ROTCTRL_INTR_MASK  in  1  1 = interrupt suppressed
I_ROTCTRL_INTR_CLEAR  in  1  clears both status flags
I_ROTCTRL_DMA_ACK  in  1  DMA accepts current request (read data valid same cycle)
I_ROTCTRL_DMA_RDATA  in  PIX_W  read pixel
O_ROTCTRL_DMA_REQ  out  1  request valid
O_ROTCTRL_DMA_WR  out  1  1=write, 0=read
O_ROTCTRL_DMA_ADDR  out  ADDR_W  byte address
O_ROTCTRL_DMA_WDATA  out  PIX_W  write pixel
O_ROTCTRL_NEW_H  out  DIM_W  rotated height
O_ROTCTRL_NEW_W  out  DIM_W  rotated width
O_ROTCTRL_BUSY  out  1  operation in progress
O_ROTCTRL_BEF_MASK  out  1  status: operation started
O_ROTCTRL_AFT_MASK  out  1  status: operation completed
O_ROTCTRL_INTR  out  1  interrupt

Behaviour:
- Reset (async, I_ROTCTRL_RESET=1): all outputs 0, FSM in IDLE, start edge detector cleared, latched config 0.
- Effective rotation: E = DIR ? (4-MODE) mod 4 : MODE, in quarter turns clockwise.
- NEW_H/NEW_W: E odd -> (W,H); E even -> (H,W).
- Source pixel (r,c), 0<=r<H, 0<=c<W, is read at SRC + (r*W + c)*BPP.
- Destination address, written to DST + offset*BPP:
  - E=0: offset = r*W + c
  - E=1: offset = c*H + (H-1-r)
  - E=2: offset = (H-1-r)*W + (W-1-c)
  - E=3: offset = (W-1-c)*H + r
- Address arithmetic is modulo 2^ADDR_W.
- FSM states: IDLE, RD, WR, DONE.
  - IDLE: on START rising edge, latch SRC, DST, H, W, E. Update NEW_H/NEW_W. Set BEF_MASK and clear AFT_MASK. Go to RD; if H=0 or W=0, go to DONE instead.
  - RD: REQ=1, WR=0, ADDR=source address. On ACK, capture RDATA into the pixel register and go to WR.
  - WR: REQ=1, WR=1, ADDR=destination address, WDATA=pixel register. On ACK: if (r,c) is the last pixel (H-1,W-1), go to DONE; otherwise advance (c+1, wrapping to 0 with r+1) and go to RD.
  - DONE: one cycle. Set AFT_MASK, then return to IDLE.
- DMA handshake:
  - REQ, WR, ADDR and WDATA are held stable until the ACK cycle.
  - ACK outside RD/WR is ignored.
  - REQ may stay high across back-to-back transfers.
  - Zero-wait ACK gives 2 cycles/pixel; total = 2*H*W + 2 cycles from start edge to AFT_MASK high.
- BUSY = 1 in RD, WR and DONE.
- START rising edge while BUSY is ignored, with no relatch. START held high does not retrigger.
- INTR = ~INTR_MASK & (BEF_MASK | AFT_MASK), registered (one-cycle lag).
- INTR_CLEAR clears BEF_MASK and AFT_MASK. If INTR_CLEAR coincides with a set event in the same cycle, the set wins.
- SRST: next edge FSM -> IDLE, REQ=0, flags cleared, NEW_H/NEW_W retained. Overrides START in the same cycle. A DMA ACK arriving in the SRST cycle is discarded.
- Config inputs changing while BUSY do not affect the running operation.

Test Plan:
- 2x3 image, pixels 0..5 at SRC=0x1000, DST=0x2000, MODE=01, DIR=0, zero-wait ACK -> dst bytes [3,0,4,1,5,2]; NEW_H=3, NEW_W=2; AFT_MASK high 14 cycles after start edge.
- Same image, MODE=10 -> dst [5,4,3,2,1,0]. MODE=01, DIR=1 -> dst [2,5,1,4,0,3], NEW_H=3, NEW_W=2.
- Random ACK delays of 0-5 cycles, MODE=11 -> REQ/ADDR/WR stable until ACK; result identical to zero-wait run.
- H=0, W=5, START -> no REQ ever; BEF_MASK and AFT_MASK set within 2 cycles; INTR=1 when mask=0 and stays 0 when mask=1.
- SRST asserted in the 3rd WR cycle -> REQ=0 next cycle, BUSY=0, flags 0. A new START then runs to completion correctly.
- Second START pulse mid-operation, plus INTR_CLEAR coinciding with the DONE cycle -> no restart; AFT_MASK=1 after the clear.
